rf_write_packer_32b_64b: RTL and testbench
==========================================

# rf_write_packer_32b_64b

Upstream write-side feeder for the 64-bit-write / 32-bit-read register file used in the SCM/FPGA memory cuts. It accepts a 32-bit valid/ready word stream and packs consecutive word pairs into 64-bit rows, low word first. It issues one registered row write per pair at incrementing row addresses starting from a programmed base. A later 32-bit read at address `{row, 0}` returns the first word of the pair, and `{row, 1}` returns the second.

## Interface
Parameters:
- `WADDR_WIDTH`, 5: row address width of the downstream register file.
- `W_N_ROWS`, `2**WADDR_WIDTH`: number of writable rows; the last row index is `W_N_ROWS-1`.
- `PAD_VALUE`, 32'h0000_0000: value written to the high half when a burst ends on an odd word.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: begin a burst. Sampled only in IDLE.
- `base_addr`, in, `WADDR_WIDTH`: first row, captured with `start`.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: input word accepted when `in_valid && in_ready`.
- `in_data`, in, 32: input word.
- `in_last`, in, 1: qualifies the accepted word as the final word of the burst.
- `WriteEnable`, out, 1: row write strobe to the register file.
- `WriteAddr`, out, `WADDR_WIDTH`: row address.
- `WriteData`, out, 64: `{hi_word, lo_word}`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse marking the end of a burst.
- `overflow`, out, 1: sticky flag; the burst stopped at the last row before `in_last`. Cleared by the next accepted `start`.
- `rows_written`, out, `WADDR_WIDTH+1`: rows written in the current or last burst. Cleared on `start`.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - LO: `in_ready`=1; waiting for the low word.
  - HI: `in_ready`=1; waiting for the high word.
  - END: `in_ready`=0; lasts 1 cycle.
- IDLE → LO on `start`. On the same edge: `addr<=base_addr`, `rows_written<=0`, `overflow<=0`.
- LO, word accepted, `in_last`=0: `lo<=in_data`, go to HI.
- LO, word accepted, `in_last`=1: write `{PAD_VALUE, in_data}` at `addr`, go to END.
- HI, word accepted: write `{in_data, lo}` at `addr`.
  - If `in_last`=1, go to END.
  - Else if `addr==W_N_ROWS-1`, set `overflow`=1 and go to END.
  - Else `addr<=addr+1` and go to LO.
- END → IDLE unconditionally.
- Each write increments `rows_written`. Address arithmetic never wraps: a burst never writes past row `W_N_ROWS-1`.
- `in_ready` is a function of state only, never of `in_valid`.
- `start` outside IDLE is ignored. `in_valid` in IDLE or END is ignored; no word is consumed.
- A burst whose first word carries `in_last` writes exactly one padded row.

## Timing
- Reset values:
  - State IDLE; `in_ready`, `busy`, `done`, `overflow` = 0.
  - `WriteEnable`=0, `WriteAddr`=0, `WriteData`=0, `rows_written`=0.
  - Internal `lo` and `addr` = 0.
- `WriteEnable`, `WriteAddr` and `WriteData` are registered:
  - The write appears in the cycle after the accepting edge and lasts exactly 1 cycle.
  - `WriteAddr` and `WriteData` hold their values when `WriteEnable`=0.
- `done` is asserted in the END cycle, i.e. the same cycle as the final `WriteEnable`.
- `busy` rises the cycle after `start` and falls the cycle after END.
- Sustained throughput: 1 word per cycle, 1 row write per 2 cycles. Bubbles on `in_valid` stall the state without side effects.
- Minimum burst-to-burst gap: `start` is sampled the cycle after END, i.e. 2 cycles after the last accepted word.
- Reset asserted mid-burst:
  - Takes effect on the next edge; the state returns to IDLE.
  - A pending low half is discarded and never written.
  - A registered write in flight is cleared: `WriteEnable` is 0 in the cycle after the reset edge.

## Test plan
- Base 3, words `A0..A3`, `in_last` on `A3`, `in_valid` held high → writes row 3=`{A1,A0}` and row 4=`{A3,A2}` on consecutive odd cycles; `done` with the second write; `rows_written`=2; `overflow`=0.
- Base 7, words `11,22,33` with `in_last` on `33` → row 7=`{22,11}`, row 8=`{PAD_VALUE,33}`; `rows_written`=2.
- Base 30 (`W_N_ROWS`=32), 6 words, no `in_last` → rows 30 and 31 written; `overflow`=1; `done` pulses; 5th word not accepted (`in_ready`=0); no write to row 0.
- Random `in_valid` gaps (50%) over 16 words → packed row contents and addresses identical to the gap-free run; `WriteEnable` never high for 2 consecutive cycles.
- Reset asserted while in HI after 1 word → no `WriteEnable`; all outputs at reset values next cycle; a new `start` at base 0 then writes row 0 correctly.
- `start` pulsed during a burst and during END → ignored; `base_addr` changes have no effect until IDLE.

Source files
------------

// File: rtl/rf_write_packer_32b_64b.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_packer_32b_64b
// Purpose  : Packs a 32-bit valid/ready word stream into 64-bit register-file
//            row writes (low word first) at incrementing rows from a base.
//            An odd trailing word is padded; the burst stops at the last row.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_packer_32b_64b #(
    parameter int          WADDR_WIDTH = 5,
    parameter int          W_N_ROWS    = 2**WADDR_WIDTH,
    parameter logic [31:0] PAD_VALUE   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WADDR_WIDTH-1:0]   base_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    input  logic                     in_last,
    output logic                     WriteEnable,
    output logic [WADDR_WIDTH-1:0]   WriteAddr,
    output logic [63:0]              WriteData,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [WADDR_WIDTH:0]     rows_written
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_END  = 2'd3
    } state_t;

    localparam logic [WADDR_WIDTH-1:0] c_LAST_ROW = WADDR_WIDTH'(W_N_ROWS - 1);
    localparam logic [WADDR_WIDTH-1:0] c_ADDR_ONE = WADDR_WIDTH'(1);
    localparam logic [WADDR_WIDTH:0]   c_ROWS_ONE = (WADDR_WIDTH+1)'(1);

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_ready;
    logic                     w_accept;
    logic [31:0]              r_lo;
    logic [WADDR_WIDTH-1:0]   r_addr;
    logic                     r_we;
    logic [WADDR_WIDTH-1:0]   r_waddr;
    logic [63:0]              r_wdata;
    logic                     r_ovf;
    logic [WADDR_WIDTH:0]     r_rows;

    // Ready depends on state alone so upstream never sees a valid->ready path.
    assign w_ready  = (r_state == S_LO) || (r_state == S_HI);
    assign w_accept = in_valid && w_ready;

    assign in_ready     = w_ready;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_END);
    assign overflow     = r_ovf;
    assign rows_written = r_rows;
    assign WriteEnable  = r_we;
    assign WriteAddr    = r_waddr;
    assign WriteData    = r_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the burst ends on in_last or when the last row fills.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start)    w_next = S_LO;
            S_LO:   if (w_accept) w_next = in_last ? S_END : S_HI;
            S_HI:   if (w_accept) w_next = (in_last || (r_addr == c_LAST_ROW)) ? S_END : S_LO;
            S_END:                w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
    end

    // Datapath: capture low word, issue registered row writes, track counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo    <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_ovf   <= 1'b0;
            r_rows  <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr <= base_addr;
                        r_rows <= '0;
                        r_ovf  <= 1'b0;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        if (in_last) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_addr;
                            r_wdata <= {PAD_VALUE, in_data};
                            r_rows  <= r_rows + c_ROWS_ONE;
                        end else begin
                            r_lo <= in_data;
                        end
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= {in_data, r_lo};
                        r_rows  <= r_rows + c_ROWS_ONE;
                        if (!in_last) begin
                            // Never wrap: stop with overflow at the last row.
                            if (r_addr == c_LAST_ROW) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_addr <= r_addr + c_ADDR_ONE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_packer_32b_64b.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_packer_32b_64b
// Purpose  : Self-checking bench for rf_write_packer_32b_64b with randomized
//            words and a burst-level reference model of the packed rows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_packer_32b_64b;

    localparam int          AW   = 5;
    localparam int          NR   = 32;
    localparam logic [31:0] PAD  = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          WriteEnable;
    logic [AW-1:0] WriteAddr;
    logic [63:0]   WriteData;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   rows_written;

    int total = 0;
    int bad   = 0;

    rf_write_packer_32b_64b #(
        .WADDR_WIDTH (AW),
        .W_N_ROWS    (NR),
        .PAD_VALUE   (PAD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .WriteEnable  (WriteEnable),
        .WriteAddr    (WriteAddr),
        .WriteData    (WriteData),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .rows_written (rows_written)
    );

    always #5 clk = ~clk;

    // Observed write log.
    int            cyc = 0;
    logic [AW-1:0] q_addr[$];
    logic [63:0]   q_data[$];
    int            q_cyc[$];
    int            done_cyc[$];
    bit            b2b = 1'b0;
    bit            prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (WriteEnable === 1'b1) begin
            q_addr.push_back(WriteAddr);
            q_data.push_back(WriteData);
            q_cyc.push_back(cyc);
            if (prev_we) b2b = 1'b1;
        end
        prev_we = (WriteEnable === 1'b1);
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    // Stimulus words and expected results.
    logic [31:0]   wd[$];
    logic [AW-1:0] exp_addr[$];
    logic [63:0]   exp_data[$];
    int            exp_acc;
    bit            exp_ovf;
    int            acc;
    logic          obs_busy_start, obs_ready_end, obs_busy_end;

    task automatic clear_mon();
        q_addr = {}; q_data = {}; q_cyc = {}; done_cyc = {}; b2b = 1'b0;
    endtask

    // Burst-level model: rows are word pairs, capped by the rows left above base.
    task automatic model(input int base, input int n, input bit last_end);
        int cap, rows;
        logic [31:0] hi;
        cap = NR - base;
        exp_addr = {}; exp_data = {};
        if (last_end && ((n + 1) / 2) <= cap) begin
            exp_acc = n; rows = (n + 1) / 2; exp_ovf = 1'b0;
        end else begin
            exp_acc = 2 * cap; rows = cap; exp_ovf = 1'b1;
        end
        for (int k = 0; k < rows; k++) begin
            hi = (2*k + 1 < exp_acc) ? wd[2*k+1] : PAD;
            exp_addr.push_back(AW'(base + k));
            exp_data.push_back({hi, wd[2*k]});
        end
    endtask

    // Drives one burst from IDLE through END; leaves the DUT in IDLE at a negedge.
    task automatic run_burst(input int base, input int n, input bit last_end,
                             input int gap, input bit noise);
        int budget;
        clear_mon();
        acc = 0; budget = 0;
        @(negedge clk);
        start = 1'b1; base_addr = AW'(base);
        @(negedge clk);
        start = 1'b0;
        obs_busy_start = busy;
        while (done !== 1'b1 && budget < 400) begin
            if (acc < n && $urandom_range(99) >= gap) begin
                in_valid = 1'b1; in_data = wd[acc]; in_last = last_end && (acc == n - 1);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            if (noise) begin
                start = 1'($urandom_range(1)); base_addr = AW'($urandom);
            end
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            budget++;
        end
        if (budget >= 400) begin
            total++; bad++;
            $display("FAIL burst_timeout: done never seen after %0d cycles", budget);
        end
        // END cycle: offer another word and (optionally) a start; both must be ignored.
        in_valid = (acc < n); in_data = (acc < n) ? wd[acc] : 32'h0; in_last = 1'b0;
        start = noise;
        #1;
        obs_ready_end = in_ready;
        if (in_valid && in_ready) acc++;
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        obs_busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({in_ready, busy, done, overflow, WriteEnable} !== 5'b0) begin bad++;
            $display("FAIL reset_flags: got %b want 00000", {in_ready, busy, done, overflow, WriteEnable}); end
        total++; if (WriteAddr !== '0 || WriteData !== '0 || rows_written !== '0) begin bad++;
            $display("FAIL reset_data: addr=%0d data=%h rows=%0d want 0", WriteAddr, WriteData, rows_written); end
        rst = 1'b0; clear_mon();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || q_addr.size() != 0) begin bad++;
            $display("FAIL idle_valid_ignored: busy=%b writes=%0d want 0/0", busy, q_addr.size()); end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        wd = {}; repeat (4) wd.push_back($urandom);
        run_burst(3, 4, 1'b1, 0, 1'b0);
        model(3, 4, 1'b1);
        total++; if (obs_busy_start !== 1'b1) begin bad++;
            $display("FAIL basic_busy_rise: got %b want 1", obs_busy_start); end
        total++; if (q_addr.size() != exp_addr.size()) begin bad++;
            $display("FAIL basic_nwrites: got %0d want %0d", q_addr.size(), exp_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < exp_addr.size(); k++) begin
            total++; if (q_addr[k] !== exp_addr[k] || q_data[k] !== exp_data[k]) begin bad++;
                $display("FAIL basic_row%0d: got %0d:%h want %0d:%h", k, q_addr[k], q_data[k], exp_addr[k], exp_data[k]); end
        end
        total++; if (q_cyc.size() != 2 || q_cyc[1] - q_cyc[0] != 2) begin bad++;
            $display("FAIL basic_spacing: writes=%0d want 2 writes 2 cycles apart", q_cyc.size()); end
        total++; if (done_cyc.size() != 1 || q_cyc.size() == 0 || done_cyc[0] != q_cyc[q_cyc.size()-1]) begin bad++;
            $display("FAIL basic_done: done pulses=%0d not aligned with final write", done_cyc.size()); end
        total++; if (rows_written !== 6'd2 || overflow !== 1'b0 || obs_busy_end !== 1'b0) begin bad++;
            $display("FAIL basic_status: rows=%0d ovf=%b busy=%b want 2/0/0", rows_written, overflow, obs_busy_end); end
    endtask

    task automatic test_pad();
        wd = {32'h11, 32'h22, 32'h33};
        run_burst(7, 3, 1'b1, 0, 1'b0);
        model(7, 3, 1'b1);
        total++; if (q_addr.size() != 2) begin bad++;
            $display("FAIL pad_nwrites: got %0d want 2", q_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < exp_addr.size(); k++) begin
            total++; if (q_addr[k] !== exp_addr[k] || q_data[k] !== exp_data[k]) begin bad++;
                $display("FAIL pad_row%0d: got %0d:%h want %0d:%h", k, q_addr[k], q_data[k], exp_addr[k], exp_data[k]); end
        end
        total++; if (rows_written !== 6'd2 || overflow !== 1'b0) begin bad++;
            $display("FAIL pad_status: rows=%0d ovf=%b want 2/0", rows_written, overflow); end
    endtask

    task automatic test_single_padded();
        wd = {$urandom};
        run_burst(12, 1, 1'b1, 0, 1'b0);
        model(12, 1, 1'b1);
        total++; if (q_addr.size() != 1 || q_addr[0] !== exp_addr[0] || q_data[0] !== exp_data[0]) begin bad++;
            $display("FAIL single_row: writes=%0d want one row %0d:%h", q_addr.size(), exp_addr[0], exp_data[0]); end
        total++; if (rows_written !== 6'd1) begin bad++;
            $display("FAIL single_rows: got %0d want 1", rows_written); end
    endtask

    task automatic test_overflow();
        wd = {}; repeat (6) wd.push_back($urandom);
        run_burst(30, 6, 1'b0, 0, 1'b0);
        model(30, 6, 1'b0);
        total++; if (q_addr.size() != exp_addr.size()) begin bad++;
            $display("FAIL ovf_nwrites: got %0d want %0d", q_addr.size(), exp_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < exp_addr.size(); k++) begin
            total++; if (q_addr[k] !== exp_addr[k] || q_data[k] !== exp_data[k]) begin bad++;
                $display("FAIL ovf_row%0d: got %0d:%h want %0d:%h", k, q_addr[k], q_data[k], exp_addr[k], exp_data[k]); end
        end
        total++; if (acc != exp_acc || obs_ready_end !== 1'b0) begin bad++;
            $display("FAIL ovf_accept: accepted=%0d ready_end=%b want %0d/0", acc, obs_ready_end, exp_acc); end
        total++; if (overflow !== exp_ovf || rows_written !== 6'd2 || done_cyc.size() != 1) begin bad++;
            $display("FAIL ovf_status: ovf=%b rows=%0d dones=%0d want 1/2/1", overflow, rows_written, done_cyc.size()); end
        // Overflow is sticky until the next start, then cleared.
        repeat (2) @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++;
            $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_gaps();
        int base;
        base = $urandom_range(24);
        wd = {}; repeat (16) wd.push_back($urandom);
        run_burst(base, 16, 1'b1, 50, 1'b0);
        model(base, 16, 1'b1);
        total++; if (q_addr.size() != exp_addr.size()) begin bad++;
            $display("FAIL gaps_nwrites: got %0d want %0d", q_addr.size(), exp_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < exp_addr.size(); k++) begin
            total++; if (q_addr[k] !== exp_addr[k] || q_data[k] !== exp_data[k]) begin bad++;
                $display("FAIL gaps_row%0d: got %0d:%h want %0d:%h", k, q_addr[k], q_data[k], exp_addr[k], exp_data[k]); end
        end
        total++; if (b2b !== 1'b0) begin bad++;
            $display("FAIL gaps_we_b2b: got %b want 0", b2b); end
        total++; if (overflow !== 1'b0 || rows_written !== 6'd8) begin bad++;
            $display("FAIL gaps_status: ovf=%b rows=%0d want 0/8", overflow, rows_written); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        @(negedge clk); start = 1'b1; base_addr = 5'd5;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++; if ({in_ready, busy, done, overflow, WriteEnable} !== 5'b0 || WriteAddr !== '0 ||
                     WriteData !== '0 || rows_written !== '0) begin bad++;
            $display("FAIL rstmid_outputs: flags=%b addr=%0d data=%h rows=%0d want all 0",
                     {in_ready, busy, done, overflow, WriteEnable}, WriteAddr, WriteData, rows_written); end
        total++; if (q_addr.size() != 0) begin bad++;
            $display("FAIL rstmid_nowrite: got %0d writes want 0", q_addr.size()); end
        wd = {}; repeat (2) wd.push_back($urandom);
        run_burst(0, 2, 1'b1, 0, 1'b0);
        model(0, 2, 1'b1);
        total++; if (q_addr.size() != 1 || q_addr[0] !== exp_addr[0] || q_data[0] !== exp_data[0]) begin bad++;
            $display("FAIL rstmid_restart: writes=%0d want row %0d:%h", q_addr.size(), exp_addr[0], exp_data[0]); end
        // Reset landing on the cycle of a visible write clears the strobe.
        @(negedge clk); start = 1'b1; base_addr = 5'd9;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        total++; if (WriteEnable !== 1'b1) begin bad++;
            $display("FAIL rstwe_pre: got %b want 1", WriteEnable); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++; if (WriteEnable !== 1'b0 || rows_written !== '0 || busy !== 1'b0) begin bad++;
            $display("FAIL rstwe_post: we=%b rows=%0d busy=%b want 0/0/0", WriteEnable, rows_written, busy); end
    endtask

    task automatic test_start_ignored();
        int base;
        base = $urandom_range(20);
        wd = {}; repeat (8) wd.push_back($urandom);
        run_burst(base, 8, 1'b1, 25, 1'b1);
        model(base, 8, 1'b1);
        total++; if (q_addr.size() != exp_addr.size()) begin bad++;
            $display("FAIL startign_nwrites: got %0d want %0d", q_addr.size(), exp_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < exp_addr.size(); k++) begin
            total++; if (q_addr[k] !== exp_addr[k] || q_data[k] !== exp_data[k]) begin bad++;
                $display("FAIL startign_row%0d: got %0d:%h want %0d:%h", k, q_addr[k], q_data[k], exp_addr[k], exp_data[k]); end
        end
        total++; if (obs_busy_end !== 1'b0) begin bad++;
            $display("FAIL startign_end: busy after END=%b want 0", obs_busy_end); end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            int base, n;
            base = $urandom_range(26);
            n = $urandom_range(1, 9);
            wd = {}; repeat (n) wd.push_back($urandom);
            run_burst(base, n, 1'b1, 0, 1'b0);
            model(base, n, 1'b1);
            total++; if (q_addr.size() != exp_addr.size() || rows_written !== (AW+1)'(exp_addr.size())) begin bad++;
                $display("FAIL b2b%0d_count: writes=%0d rows=%0d want %0d", b, q_addr.size(), rows_written, exp_addr.size()); end
            for (int k = 0; k < q_addr.size() && k < exp_addr.size(); k++) begin
                total++; if (q_addr[k] !== exp_addr[k] || q_data[k] !== exp_data[k]) begin bad++;
                    $display("FAIL b2b%0d_row%0d: got %0d:%h want %0d:%h", b, k, q_addr[k], q_data[k], exp_addr[k], exp_data[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_single_padded();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
